avl_multi_timer: RTL and testbench
==================================

# avl_multi_timer

Parametrised multi-channel Avalon-MM interval timer, successor of the fixed single-channel 16-bit timer in the Nios subsystem. Each channel has a software-writable period, one-shot/continuous mode, snapshot capture and an overrun flag; per-channel interrupts are ORed onto one `irq` line for the Nios IRQ input. It sits on the Avalon-MM data master as a plain slave with fixed one-cycle read latency.

## Interface
- `NUM_CH`, 2: number of channels, 1–4.
- `CNT_W`, 32: counter/period width, 8–32.
- `DEFAULT_PERIOD`, 49999: reset value of every PERIOD register and counter.
- `ADDR_W`, derived = 2 + clog2(NUM_CH), min 3: word-address width.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in ADDR_W: word address; [1:0] register, [ADDR_W-1:2] channel.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: OR of all channel interrupts.
- `irq_vec` out NUM_CH: per-channel interrupt, bit n = channel n.

## Operation
- Register map per channel: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAPSHOT. Channel index ≥ NUM_CH: reads 0, writes ignored.
- STATUS (RO except clear): [0] TO timeout, [1] RUN, [2] OVR overrun. Any write clears TO and OVR.
- CONTROL: [0] IE, [1] CONT, [2] START (strobe, reads 0), [3] STOP (strobe, reads 0), [15:8] PRESC (with macro only). Bits [1:0] and PRESC stored on write.
- PERIOD: write stores writedata[CNT_W-1:0], loads counter with same value, clears RUN, resets prescaler. Reads stored period, zero-extended.
- SNAPSHOT: any write captures current counter; reads captured value, zero-extended.
- Counting: while RUN, counter decrements on each tick. Tick when RUN and count == 0: counter reloads PERIOD, TO set, OVR set if TO already 1, RUN cleared if CONT = 0. Interval = (PERIOD + 1) ticks.
- START and STOP in the same write: START wins. START while running: no reload, counting continues. STOP: RUN cleared, counter holds its value.
- TO set and STATUS write on the same edge: TO ends 1, OVR ends 0. The event is never lost.
- `irq_vec[n]` = TO[n] & IE[n], combinational from registers. `irq` = OR of `irq_vec`.
- PERIOD = 0 in continuous mode: TO on every tick.

## Timing
- Reset: counters and PERIOD = DEFAULT_PERIOD; CONTROL, STATUS, SNAPSHOT, prescalers, `readdata` = 0; `irq` and `irq_vec` = 0.
- Write effects visible from the edge that samples the write. START at edge k: first decrement at edge k+1 (PRESC = 0).
- `readdata` registered every clock from the `address` mux, with no read strobe: valid 1 cycle after address is presented.
- Timeout edge to `irq` high: 0 cycles after the TO register update.
- Reset asserted mid-count: all state returns to reset values immediately. No pending timeout survives.

## Configuration
- `AVL_TIMER_PRESCALER_EN` defined: per-channel 8-bit prescaler. A tick occurs every PRESC+1 clocks; the prescaler restarts on START and on PERIOD write.
- Not defined: tick on every clock; CONTROL[15:8] reads 0 and writes to it are ignored; no prescaler logic.

## Structure
- Package `avl_timer_pkg` holds:
  - register offsets (REG_STATUS, REG_CONTROL, REG_PERIOD, REG_SNAPSHOT);
  - CONTROL bit positions;
  - STATUS bit positions;
  - PRESC field bounds.
- Sub-module `avl_timer_channel` holds one channel's counter, period, control, status, snapshot and prescaler. The top instantiates NUM_CH copies and contains address decode, the read mux, the `readdata` register and the IRQ OR.

## Test plan
- Reset, read ch0 PERIOD: readdata = 49999 one cycle after address. All other registers read 0; `irq` = 0.
- Ch1 PERIOD = 4, CONTROL = 0x7 (IE, CONT, START): TO/`irq_vec[1]` rise every 5 clocks. RUN stays 1.
- Ch0 PERIOD = 3, CONTROL = 0x5 (one-shot): TO rises 4 clocks after START. RUN = 0 afterwards; counter reads back 3 via SNAPSHOT.
- Ch0 continuous, PERIOD = 2, STATUS never cleared: OVR = 1 after second timeout. A STATUS write on the same edge as a timeout leaves TO = 1, OVR = 0.
- CONTROL write 0xC (START+STOP) → RUN = 1. Write 0x8 mid-count → counter frozen; snapshots taken 10 cycles apart are equal.
- With `AVL_TIMER_PRESCALER_EN`, PRESC = 3, PERIOD = 1, continuous: TO every 8 clocks. Without the macro, CONTROL readback of 0x0307 returns 0x0003.

Source files
------------

// File: rtl/avl_timer_pkg.sv
// avl_timer_pkg: register map, bit positions and address sizing for avl_multi_timer
package avl_timer_pkg;
   localparam logic [1:0] REG_STATUS   = 2'd0;
   localparam logic [1:0] REG_CONTROL  = 2'd1;
   localparam logic [1:0] REG_PERIOD   = 2'd2;
   localparam logic [1:0] REG_SNAPSHOT = 2'd3;
   localparam int CTL_IE    = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;
   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;
   localparam int ST_OVR = 2;
   localparam int PRESC_LO = 8;
   localparam int PRESC_HI = 15;
   function automatic int addr_w(int n);
      return (2 + $clog2(n) < 3) ? 3 : 2 + $clog2(n);
   endfunction
endpackage

// File: rtl/avl_multi_timer_if.sv
// avl_multi_timer_if: Avalon-MM slave bus with fixed one-cycle read latency
interface avl_multi_timer_if #(parameter int ADDR_W = 3);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avl_timer_channel.sv
// avl_timer_channel: one timer channel (counter, period, control, status, snapshot);
// the 8-bit prescaler exists only when AVL_TIMER_PRESCALER_EN is defined
module avl_timer_channel import avl_timer_pkg::*; #(
   parameter int CNT_W          = 32,
   parameter int DEFAULT_PERIOD = 49999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        we,
   input  logic [1:0]  sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_PERIOD);
   logic [CNT_W-1:0] period, cnt, snap;
   logic             ie, cont, run, to, ovr;
   logic             wr_st, wr_ctl, wr_per, wr_snap, start, stop, tick, expire;
   logic [7:0]       presc;
   assign wr_st   = we & (sel == REG_STATUS);
   assign wr_ctl  = we & (sel == REG_CONTROL);
   assign wr_per  = we & (sel == REG_PERIOD);
   assign wr_snap = we & (sel == REG_SNAPSHOT);
   assign start   = wr_ctl & wdata[CTL_START];
   assign stop    = wr_ctl & wdata[CTL_STOP] & ~wdata[CTL_START];
`ifdef AVL_TIMER_PRESCALER_EN
   logic [7:0] pcnt;
   assign tick = run & (pcnt == 8'd0);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         presc <= '0;
         pcnt  <= '0;
      end else begin
         if (wr_ctl) presc <= wdata[PRESC_HI:PRESC_LO];
         if (wr_per) pcnt <= '0;
         else if (start) pcnt <= wdata[PRESC_HI:PRESC_LO];
         else if (run) pcnt <= (pcnt == 8'd0) ? presc : pcnt - 8'd1;
      end
`else
   assign presc = '0;
   assign tick  = run;
`endif
   assign expire = tick & (cnt == '0);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         period <= DEF;
         cnt    <= DEF;
         snap   <= '0;
         ie     <= 1'b0;
         cont   <= 1'b0;
         run    <= 1'b0;
         to     <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         if (wr_per) cnt <= wdata[CNT_W-1:0];
         else if (tick) cnt <= expire ? period : cnt - CNT_W'(1);
         if (wr_per) period <= wdata[CNT_W-1:0];
         if (wr_snap) snap <= cnt;
         if (wr_ctl) begin
            ie   <= wdata[CTL_IE];
            cont <= wdata[CTL_CONT];
         end
         run <= start | (run & ~stop & ~wr_per & ~(expire & ~cont));
         // a timeout coinciding with a STATUS write still lands in TO
         to  <= expire | (to & ~wr_st);
         ovr <= ~wr_st & (ovr | (expire & to));
      end
   assign rdata = (sel == REG_STATUS)  ? {29'd0, ovr, run, to} :
                  (sel == REG_CONTROL) ? {16'd0, presc, 6'd0, cont, ie} :
                  (sel == REG_PERIOD)  ? 32'(period) : 32'(snap);
   assign irq = to & ie;
endmodule

// File: rtl/avl_multi_timer.sv
// avl_multi_timer: NUM_CH-channel Avalon-MM interval timer with ORed irq;
// AVL_TIMER_PRESCALER_EN enables the per-channel 8-bit prescaler
module avl_multi_timer import avl_timer_pkg::*; #(
   parameter int NUM_CH         = 2,
   parameter int CNT_W          = 32,
   parameter int DEFAULT_PERIOD = 49999
) (
   input  logic              clk,
   input  logic              reset_n,
   avl_multi_timer_if.slave  avl,
   output logic              irq,
   output logic [NUM_CH-1:0] irq_vec
);
   localparam int ADDR_W = addr_w(NUM_CH);
   logic [ADDR_W-3:0] ch;
   logic              wr;
   logic [31:0]       ch_rd [NUM_CH];
   logic [31:0]       rd_mux;
   assign ch = avl.address[ADDR_W-1:2];
   assign wr = avl.chipselect & ~avl.write_n;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      avl_timer_channel #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_ch (
         .clk    (clk),
         .reset_n(reset_n),
         .we     (wr & (int'(ch) == g)),
         .sel    (avl.address[1:0]),
         .wdata  (avl.writedata),
         .rdata  (ch_rd[g]),
         .irq    (irq_vec[g])
      );
   end
   // unpopulated channel indices fall through to zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (int'(ch) == i) rd_mux = ch_rd[i];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) avl.readdata <= '0;
      else avl.readdata <= rd_mux;
   assign irq = |irq_vec;
endmodule

// File: tb/tb_avl_multi_timer.sv
// tb_avl_multi_timer: table, directed and randomized checks against a behavioural model
module tb_avl_multi_timer;
   localparam int NUM_CH = 3;
   localparam int ADDR_W = 4;
   localparam logic [31:0] DEF = 32'd49999;
`ifdef AVL_TIMER_PRESCALER_EN
   localparam bit PRESC = 1'b1;
`else
   localparam bit PRESC = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic irq;
   logic [NUM_CH-1:0] irq_vec;
   int checks = 0;
   int errors = 0;
   avl_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();
   avl_multi_timer #(.NUM_CH(NUM_CH)) dut (.clk(clk), .reset_n(reset_n), .avl(bus), .irq(irq), .irq_vec(irq_vec));
   always #5 clk = ~clk;

   logic [31:0] m_per [NUM_CH], m_cnt [NUM_CH], m_snap [NUM_CH];
   bit          m_ie [NUM_CH], m_cont [NUM_CH], m_run [NUM_CH], m_to [NUM_CH], m_ovr [NUM_CH];
   int          m_presc [NUM_CH], m_pc [NUM_CH];
   logic [31:0] m_rd;

   typedef struct {
      bit          wr;
      int          ch;
      int          rg;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < NUM_CH; n++) begin
         m_per[n] = DEF; m_cnt[n] = DEF; m_snap[n] = 0;
         m_ie[n] = 0; m_cont[n] = 0; m_run[n] = 0; m_to[n] = 0; m_ovr[n] = 0;
         m_presc[n] = 0; m_pc[n] = 0;
      end
      m_rd = 0;
   endtask

   function automatic logic [31:0] m_read(int c, int r);
      if (c >= NUM_CH) return 32'd0;
      if (r == 0) return {29'd0, m_ovr[c], m_run[c], m_to[c]};
      if (r == 1) return {16'd0, 8'(m_presc[c]), 6'd0, m_cont[c], m_ie[c]};
      if (r == 2) return m_per[c];
      return m_snap[c];
   endfunction

   function automatic logic [NUM_CH-1:0] exp_vec();
      logic [NUM_CH-1:0] v;
      for (int n = 0; n < NUM_CH; n++) v[n] = m_to[n] & m_ie[n];
      return v;
   endfunction

   // next state of every channel from the bus cycle about to be sampled
   task automatic model_next();
      int c, r;
      bit w;
      logic [31:0] d;
      c = int'(bus.address[ADDR_W-1:2]);
      r = int'(bus.address[1:0]);
      d = bus.writedata;
      w = bus.chipselect && !bus.write_n;
      m_rd = m_read(c, r);
      for (int n = 0; n < NUM_CH; n++) begin
         bit wr, tick, expd, start, stop, clr;
         wr = w && c == n;
         tick = m_run[n] && m_pc[n] == 0;
         expd = tick && m_cnt[n] == 0;
         start = wr && r == 1 && d[2];
         stop = wr && r == 1 && d[3] && !d[2];
         clr = wr && r == 0;
         if (wr && r == 3) m_snap[n] = m_cnt[n];
         if (wr && r == 2) begin
            m_per[n] = d; m_cnt[n] = d; m_pc[n] = 0;
         end else begin
            if (tick) m_cnt[n] = expd ? m_per[n] : m_cnt[n] - 1;
            if (start) m_pc[n] = PRESC ? int'(d[15:8]) : 0;
            else if (m_run[n]) m_pc[n] = (m_pc[n] == 0) ? m_presc[n] : m_pc[n] - 1;
         end
         m_ovr[n] = !clr && (m_ovr[n] || (expd && m_to[n]));
         m_to[n] = expd || (m_to[n] && !clr);
         if (start) m_run[n] = 1;
         else if (stop || (wr && r == 2) || (expd && !m_cont[n])) m_run[n] = 0;
         if (wr && r == 1) begin
            m_ie[n] = d[0]; m_cont[n] = d[1];
            if (PRESC) m_presc[n] = int'(d[15:8]);
         end
      end
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      chk("readdata", bus.readdata, m_rd);
      chk("irq_vec", 32'(irq_vec), 32'(exp_vec()));
      chk("irq", 32'(irq), 32'(|exp_vec()));
   endtask

   task automatic xfer(bit wr, int c, int r, logic [31:0] d);
      bus.address = ADDR_W'((c << 2) | r);
      bus.chipselect = 1'b1;
      bus.write_n = !wr;
      bus.writedata = d;
      step();
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
   endtask

   task automatic rd(int c, int r, logic [31:0] exp, string name);
      xfer(1'b0, c, r, 32'd0);
      chk(name, bus.readdata, exp);
   endtask

   task automatic wait_irq(int n, int exp_cycles, string name);
      int k = 0;
      while (!irq_vec[n] && k < 50) begin
         step();
         k++;
      end
      chk(name, 32'(k), 32'(exp_cycles));
   endtask

   initial begin
      int k;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("reset_irq", 32'(irq), 32'd0);
      chk("reset_irq_vec", 32'(irq_vec), 32'd0);
      chk("reset_readdata", bus.readdata, 32'd0);

      tbl.push_back('{0, 0, 2, 0, DEF});
      tbl.push_back('{0, 0, 0, 0, 32'd0});
      tbl.push_back('{0, 0, 1, 0, 32'd0});
      tbl.push_back('{0, 0, 3, 0, 32'd0});
      tbl.push_back('{0, 1, 2, 0, DEF});
      tbl.push_back('{0, 2, 2, 0, DEF});
      tbl.push_back('{0, 3, 2, 0, 32'd0});
      tbl.push_back('{1, 3, 2, 32'd5, 32'd0});
      tbl.push_back('{0, 3, 2, 0, 32'd0});
      tbl.push_back('{0, 2, 2, 0, DEF});
      tbl.push_back('{1, 2, 1, 32'h0307, 32'd0});
      tbl.push_back('{0, 2, 1, 0, PRESC ? 32'h0307 : 32'h0003});
      tbl.push_back('{0, 2, 0, 0, 32'h2});
      tbl.push_back('{1, 2, 1, 32'h8, 32'd0});
      tbl.push_back('{0, 2, 0, 0, 32'h0});
      tbl.push_back('{0, 2, 1, 0, 32'h0});
      foreach (tbl[i]) begin
         if (tbl[i].wr) xfer(1'b1, tbl[i].ch, tbl[i].rg, tbl[i].wd);
         else rd(tbl[i].ch, tbl[i].rg, tbl[i].exp, $sformatf("tbl%0d", i));
      end

      // continuous channel 1, period 4
      xfer(1'b1, 1, 2, 32'd4);
      xfer(1'b1, 1, 1, 32'h7);
      wait_irq(1, 5, "cont_first_to");
      xfer(1'b1, 1, 0, 32'd0);
      wait_irq(1, 4, "cont_second_to");
      xfer(1'b0, 1, 0, 32'd0);
      chk("cont_run", 32'(bus.readdata[1]), 32'd1);
      xfer(1'b1, 1, 1, 32'h8);
      xfer(1'b1, 1, 0, 32'd0);

      // one-shot channel 0, period 3
      xfer(1'b1, 0, 2, 32'd3);
      xfer(1'b1, 0, 1, 32'h5);
      wait_irq(0, 4, "oneshot_to");
      rd(0, 0, 32'h1, "oneshot_status");
      xfer(1'b1, 0, 3, 32'd0);
      rd(0, 3, 32'd3, "oneshot_snapshot");

      // overrun, then STATUS write on a timeout edge
      xfer(1'b1, 0, 0, 32'd0);
      xfer(1'b1, 0, 2, 32'd2);
      xfer(1'b1, 0, 1, 32'h7);
      wait_irq(0, 3, "ovr_first_to");
      repeat (3) step();
      rd(0, 0, 32'h7, "ovr_status");
      k = 0;
      while (!(m_run[0] && m_cnt[0] == 0 && m_pc[0] == 0) && k < 20) begin
         step();
         k++;
      end
      chk("align_bound", 32'(k < 20), 32'd1);
      xfer(1'b1, 0, 0, 32'd0);
      rd(0, 0, 32'h3, "clear_on_timeout");

      // START+STOP together, then freeze
      xfer(1'b1, 0, 2, 32'd100);
      xfer(1'b1, 0, 0, 32'd0);
      xfer(1'b1, 0, 1, 32'hC);
      rd(0, 0, 32'h2, "start_wins");
      repeat (5) step();
      xfer(1'b1, 0, 1, 32'h8);
      xfer(1'b1, 0, 3, 32'd0);
      rd(0, 3, 32'd93, "freeze_snap1");
      repeat (10) step();
      xfer(1'b1, 0, 3, 32'd0);
      rd(0, 3, 32'd93, "freeze_snap2");

`ifdef AVL_TIMER_PRESCALER_EN
      xfer(1'b1, 0, 2, 32'd1);
      xfer(1'b1, 0, 0, 32'd0);
      xfer(1'b1, 0, 1, 32'h0307);
      wait_irq(0, 8, "presc_first_to");
      xfer(1'b1, 0, 0, 32'd0);
      wait_irq(0, 7, "presc_second_to");
`endif

      for (int i = 0; i < 1500; i++) begin
         int c, r;
         logic [31:0] d;
         c = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         d = (r == 2) ? 32'($urandom_range(0, 6)) :
             (r == 1) ? {16'd0, 8'($urandom_range(0, 2)), 4'd0, 4'($urandom)} : $urandom;
         if ($urandom_range(0, 2) == 0) xfer($urandom_range(0, 1) == 1, c, r, d);
         else begin
            bus.address = ADDR_W'($urandom);
            step();
         end
      end

      // reset in the middle of activity
      xfer(1'b1, 1, 2, 32'd2);
      xfer(1'b1, 1, 1, 32'h7);
      repeat (4) step();
      #3 reset_n = 1'b0;
      #1;
      chk("midreset_irq", 32'(irq), 32'd0);
      chk("midreset_irq_vec", 32'(irq_vec), 32'd0);
      chk("midreset_readdata", bus.readdata, 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      rd(0, 2, DEF, "post_reset_period");
      rd(1, 0, 32'd0, "post_reset_status");
      repeat (10) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
